// File: rtl/fetch_stage.sv
// fetch_stage: instruction-fetch stage of the ARM pipeline.
// Holds the PC, its +4 incrementer, the branch-redirect mux and the IF/ID
// latch. A branch seen while the pipe is stalled is parked as a pending
// redirect and applied on the first edge the stall lifts.
module fetch_stage #(
    parameter int                     PC_WIDTH    = 8,
    parameter int                     INSTR_WIDTH = 32,
    parameter logic [PC_WIDTH-1:0]    RESET_PC    = 8'h00,
    parameter logic [INSTR_WIDTH-1:0] NOP_INSTR   = 32'h00000000
) (
    input  logic                   Clk,
    input  logic                   Clr,
    input  logic                   LE,
    input  logic                   branch_taken,
    input  logic [PC_WIDTH-1:0]    branch_target,
    input  logic [INSTR_WIDTH-1:0] instr_in,
    output logic [PC_WIDTH-1:0]    rom_addr,
    output logic [INSTR_WIDTH-1:0] id_instr,
    output logic [PC_WIDTH-1:0]    id_next_pc,
    output logic                   id_valid,
    output logic [3:0]             I31_28,
    output logic [3:0]             I19_16,
    output logic [3:0]             I15_12,
    output logic [3:0]             I3_0,
    output logic [23:0]            I23_0,
    output logic [11:0]            I11_0,
    output logic                   redirect_pending,
    output logic [15:0]            fetch_count
);

    // RUN: normal fetch. PEND: a redirect was captured during a stall.
    typedef enum logic {
        RUN  = 1'b0,
        PEND = 1'b1
    } state_t;

    state_t                   state;
    state_t                   state_nxt;
    logic [PC_WIDTH-1:0]      pc;
    logic [PC_WIDTH-1:0]      pc_nxt;
    logic [PC_WIDTH-1:0]      pc_plus4;
    logic [PC_WIDTH-1:0]      live_target;
    logic [PC_WIDTH-1:0]      pend_target;
    logic [PC_WIDTH-1:0]      pend_target_nxt;
    logic [INSTR_WIDTH-1:0]   id_instr_nxt;
    logic [PC_WIDTH-1:0]      id_next_pc_nxt;
    logic                     id_valid_nxt;
    logic [15:0]              fetch_count_nxt;

    // Counter increment that sticks at all-ones instead of wrapping.
    function automatic logic [15:0] sat_inc(input logic [15:0] v);
        return (v == 16'hFFFF) ? v : v + 16'd1;
    endfunction

    // Branch targets are word addresses; the two byte-offset bits are dropped.
    function automatic logic [PC_WIDTH-1:0] word_align(input logic [PC_WIDTH-1:0] a);
        return a & ~PC_WIDTH'(3);
    endfunction

    // Incrementer wraps modulo 2^PC_WIDTH; carry out is discarded.
    assign pc_plus4    = pc + PC_WIDTH'(4);
    assign live_target = word_align(branch_target);

    assign rom_addr         = pc;
    assign redirect_pending = (state == PEND);

    // Decoded field slices of the latched instruction (show NOP fields in a bubble).
    assign I31_28 = id_instr[31:28];
    assign I19_16 = id_instr[19:16];
    assign I15_12 = id_instr[15:12];
    assign I3_0   = id_instr[3:0];
    assign I23_0  = id_instr[23:0];
    assign I11_0  = id_instr[11:0];

    // Next-state and next-register logic; everything holds unless a case below moves it.
    always_comb begin
        state_nxt       = state;
        pc_nxt          = pc;
        pend_target_nxt = pend_target;
        id_instr_nxt    = id_instr;
        id_next_pc_nxt  = id_next_pc;
        id_valid_nxt    = id_valid;
        fetch_count_nxt = fetch_count;
        case (state)
            RUN: begin
                if (LE) begin
                    if (branch_taken) begin
                        // Redirect and squash the wrong-path slot; id_next_pc keeps its old value.
                        pc_nxt       = live_target;
                        id_instr_nxt = NOP_INSTR;
                        id_valid_nxt = 1'b0;
                    end else begin
                        pc_nxt          = pc_plus4;
                        id_instr_nxt    = instr_in;
                        id_next_pc_nxt  = pc_plus4;
                        id_valid_nxt    = 1'b1;
                        fetch_count_nxt = sat_inc(fetch_count);
                    end
                end else if (branch_taken) begin
                    pend_target_nxt = live_target;
                    state_nxt       = PEND;
                end
            end
            PEND: begin
                if (LE) begin
                    // A branch arriving on the release edge is newer than the parked one.
                    pc_nxt       = branch_taken ? live_target : pend_target;
                    id_instr_nxt = NOP_INSTR;
                    id_valid_nxt = 1'b0;
                    state_nxt    = RUN;
                end else if (branch_taken) begin
                    pend_target_nxt = live_target;
                end
            end
            default: state_nxt = RUN;
        endcase
    end

    // State, PC and IF/ID registers; Clr clears them all immediately.
    always_ff @(posedge Clk or negedge Clr) begin
        if (!Clr) begin
            state       <= RUN;
            pc          <= RESET_PC;
            pend_target <= '0;
            id_instr    <= NOP_INSTR;
            id_next_pc  <= '0;
            id_valid    <= 1'b0;
            fetch_count <= '0;
        end else begin
            state       <= state_nxt;
            pc          <= pc_nxt;
            pend_target <= pend_target_nxt;
            id_instr    <= id_instr_nxt;
            id_next_pc  <= id_next_pc_nxt;
            id_valid    <= id_valid_nxt;
            fetch_count <= fetch_count_nxt;
        end
    end

endmodule

// File: tb/tb_fetch_stage.sv
// tb_fetch_stage: directed scenarios plus random LE/branch traffic against a
// reference model of the fetch stage's documented behaviour.
module tb_fetch_stage;

    logic        Clk;
    logic        Clr;
    logic        LE;
    logic        branch_taken;
    logic [7:0]  branch_target;
    logic [31:0] instr_in;
    logic [7:0]  rom_addr;
    logic [31:0] id_instr;
    logic [7:0]  id_next_pc;
    logic        id_valid;
    logic [3:0]  I31_28, I19_16, I15_12, I3_0;
    logic [23:0] I23_0;
    logic [11:0] I11_0;
    logic        redirect_pending;
    logic [15:0] fetch_count;

    logic [31:0] rom [256];

    int n_checks;
    int n_fail;

    // Reference state
    int m_pc, m_instr, m_npc, m_valid, m_cnt, m_pend, m_ptgt;

    fetch_stage dut (
        .Clk              (Clk),
        .Clr              (Clr),
        .LE               (LE),
        .branch_taken     (branch_taken),
        .branch_target    (branch_target),
        .instr_in         (instr_in),
        .rom_addr         (rom_addr),
        .id_instr         (id_instr),
        .id_next_pc       (id_next_pc),
        .id_valid         (id_valid),
        .I31_28           (I31_28),
        .I19_16           (I19_16),
        .I15_12           (I15_12),
        .I3_0             (I3_0),
        .I23_0            (I23_0),
        .I11_0            (I11_0),
        .redirect_pending (redirect_pending),
        .fetch_count      (fetch_count)
    );

    // Combinational instruction ROM
    assign instr_in = rom[rom_addr];

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_pc = 0; m_instr = 0; m_npc = 0; m_valid = 0; m_cnt = 0; m_pend = 0; m_ptgt = 0;
    endtask

    function automatic int align4(input int a);
        return (a / 4) * 4;
    endfunction

    // What one rising edge does to the stage, given the inputs present at it.
    task automatic model_edge(input int le, input int bt, input int tgt);
        if (m_pend == 0) begin
            if (le != 0) begin
                if (bt != 0) begin
                    m_pc = align4(tgt); m_instr = 0; m_valid = 0;
                end else begin
                    m_instr = int'(rom[m_pc]);
                    m_npc   = (m_pc + 4) % 256;
                    m_pc    = m_npc;
                    m_valid = 1;
                    if (m_cnt < 65535) m_cnt = m_cnt + 1;
                end
            end else if (bt != 0) begin
                m_pend = 1; m_ptgt = align4(tgt);
            end
        end else begin
            if (le != 0) begin
                m_pc = (bt != 0) ? align4(tgt) : m_ptgt;
                m_instr = 0; m_valid = 0; m_pend = 0;
            end else if (bt != 0) begin
                m_ptgt = align4(tgt);
            end
        end
    endtask

    task automatic check_all(input string where);
        logic [31:0] mi;
        mi = m_instr;
        chk({where, ".rom_addr"},  32'(rom_addr),         32'(m_pc));
        chk({where, ".id_instr"},  id_instr,              mi);
        chk({where, ".next_pc"},   32'(id_next_pc),       32'(m_npc));
        chk({where, ".valid"},     32'(id_valid),         32'(m_valid));
        chk({where, ".pending"},   32'(redirect_pending), 32'(m_pend));
        chk({where, ".count"},     32'(fetch_count),      32'(m_cnt));
        chk({where, ".fields"},
            {I31_28, I23_0, I3_0},
            {mi[31:28], mi[23:0], mi[3:0]});
        chk({where, ".mid"},
            {8'h0, I19_16, I15_12, I11_0, 4'h0},
            {8'h0, mi[19:16], mi[15:12], mi[11:0], 4'h0});
    endtask

    // Apply inputs, clock one edge, then compare just after it.
    task automatic step(input string where, input int le, input int bt, input int tgt);
        LE            = le[0];
        branch_taken  = bt[0];
        branch_target = tgt[7:0];
        @(posedge Clk);
        model_edge(le, bt, tgt);
        #1;
        check_all(where);
    endtask

    initial begin
        n_checks = 0;
        n_fail   = 0;
        for (int i = 0; i < 256; i++) rom[i] = $urandom;
        rom[8'h00] = 32'h11; rom[8'h04] = 32'h22; rom[8'h08] = 32'h33; rom[8'h0C] = 32'h44;
        rom[8'h40] = 32'hE1A0_5A3C;

        // Reset applied with no clock edge
        Clr = 1'b0; LE = 1'b1; branch_taken = 1'b0; branch_target = 8'h00;
        #1;
        model_reset();
        check_all("reset");
        #1 Clr = 1'b1;

        // Sequential fetch
        step("seq0", 1, 0, 0);
        step("seq1", 1, 0, 0);
        // Stall at PC=08
        for (int i = 0; i < 3; i++) step("stall", 0, 0, 0);
        step("resume", 1, 0, 0);
        // Branch at PC=0C to 41 (aligned to 40), then target instruction
        step("br", 1, 1, 8'h41);
        step("br_tgt", 1, 0, 0);
        // Two branches during a stall: newest wins
        step("pend1", 0, 1, 8'h20);
        step("pend_hold", 0, 0, 0);
        step("pend2", 0, 1, 8'h33);
        step("pend_rel", 1, 0, 0);
        step("pend_run", 1, 0, 0);
        // Live branch on release edge wins over parked target
        step("live1", 0, 1, 8'h50);
        step("live_rel", 1, 1, 8'h67);
        // Wrap from FC
        step("wrap_br", 1, 1, 8'hFC);
        step("wrap", 1, 0, 0);
        step("wrap2", 1, 0, 0);

        // Random traffic
        for (int i = 0; i < 3000; i++)
            step("rand", ($urandom_range(0, 3) != 0) ? 1 : 0,
                 ($urandom_range(0, 4) == 0) ? 1 : 0, int'($urandom_range(0, 255)));

        // Asynchronous reset while a redirect is pending, between edges
        step("pre_rst", 0, 1, 8'h55);
        chk("pre_rst.pending_set", 32'(redirect_pending), 32'd1);
        Clr = 1'b0;
        #1;
        model_reset();
        check_all("async_rst");
        @(negedge Clk);
        Clr = 1'b1;
        step("post_rst", 1, 0, 0);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
